// File: rtl/cache_arbiter.sv
// Two-into-one arbiter sharing the physical-memory port between I-cache and D-cache.
// Define CACHE_ARBITER_RR_EN for round-robin on simultaneous requests (default: D over I).
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(5'h1F);

  state_t            state, state_next;
  logic              op_read, op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_line_q, d_line_q;
  logic              d_req;
  logic              grant_i, grant_d;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
  // last_grant: 1 = D-cache was served most recently, 0 = I-cache.
  logic last_grant;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req && i_read) begin
        grant_d = ~last_grant;
        grant_i = last_grant;
      end else begin
        grant_d = d_req;
        grant_i = i_read;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (grant_d) begin
      last_grant <= 1'b1;
    end else if (grant_i) begin
      last_grant <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_d = (state == IDLE) && d_req;
    grant_i = (state == IDLE) && i_read && !d_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
        end else if (grant_i) begin
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        mem_read  = op_read;
        mem_write = op_write;
        i_resp    = mem_resp;
        if (mem_resp) begin
          state_next = DONE;
        end
      end
      SERVE_D: begin
        mem_read  = op_read;
        mem_write = op_write;
        d_resp    = mem_resp;
        if (mem_resp) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Transaction is captured whole at grant so requester input changes cannot leak to memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_read  <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant_d) begin
      op_write <= d_write;
      op_read  <= d_read & ~d_write;
      addr_q   <= d_address & LINE_MASK;
      wdata_q  <= d_wdata;
    end else if (grant_i) begin
      op_write <= 1'b0;
      op_read  <= 1'b1;
      addr_q   <= i_address & LINE_MASK;
      wdata_q  <= d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_line_q <= '0;
      d_line_q <= '0;
    end else begin
      if (i_resp) begin
        i_line_q <= mem_rdata;
      end
      if (d_resp && op_read) begin
        d_line_q <= mem_rdata;
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = i_resp ? mem_rdata : i_line_q;
  assign d_rdata     = (d_resp && op_read) ? mem_rdata : d_line_q;

endmodule
